// File: rtl/mux_pipe_sel.sv
// mux_pipe_sel
//   N-way, W-bit selector with a registered output and a valid/ready
//   handshake. A 1-entry skid buffer keeps full throughput while the
//   downstream stage stalls. Beats leave in strict arrival order.
// Ports
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_bus     NUM_IN packed inputs, input k at in_bus[k*WIDTH +: WIDTH]
//   sel        input index, sampled together with in_bus
//   in_valid   upstream offers a beat
//   in_ready   stage can accept a beat (registered)
//   out_data   selected data of the beat at the head
//   out_sel    sel value that produced out_data
//   out_err    sel was out of range for this beat (out_data forced to 0)
//   out_valid  out_* hold a beat
//   out_ready  downstream accepts the beat
module mux_pipe_sel #(
  parameter int unsigned WIDTH  = 5,
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned SEL_W  = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_err,
  output logic                    out_valid,
  input  logic                    out_ready
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [SEL_W-1:0] sel;
    logic             err;
  } beat_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    MAIN  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state;
  beat_t  main_q;
  beat_t  skid_q;
  beat_t  cap;
  logic   in_fire;
  logic   out_fire;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;

  // Select without ever indexing past the bus: an unmatched sel keeps
  // the zero data and the error flag.
  always_comb begin
    cap.data = '0;
    cap.sel  = sel;
    cap.err  = 1'b1;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) begin
        cap.data = in_bus[k*WIDTH +: WIDTH];
        cap.err  = 1'b0;
      end
    end
  end

  // in_ready and out_valid are registered alongside the state so that
  // in_ready stays low through reset and rises on the first edge after.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        EMPTY: begin
          in_ready <= 1'b1;
          if (in_fire) begin
            main_q    <= cap;
            out_valid <= 1'b1;
            state     <= MAIN;
          end
        end
        MAIN: begin
          if (in_fire && out_fire) begin
            main_q <= cap;
          end else if (in_fire) begin
            skid_q   <= cap;
            in_ready <= 1'b0;
            state    <= FULL;
          end else if (out_fire) begin
            out_valid <= 1'b0;
            state     <= EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            main_q   <= skid_q;
            in_ready <= 1'b1;
            state    <= MAIN;
          end
        end
        default: begin
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
          state     <= EMPTY;
        end
      endcase
    end
  end

  assign out_data = main_q.data;
  assign out_sel  = main_q.sel;
  assign out_err  = main_q.err;

endmodule

// File: tb/tb_mux_pipe_sel.sv
// tb_mux_pipe_sel
//   Directed bench for mux_pipe_sel: a 4-input instance for reset, streaming,
//   stall/skid, back-to-back and randomized-handshake ordering, plus a
//   3-input instance for out-of-range select handling.
module tb_mux_pipe_sel;

  logic        clk;
  logic        rst;

  logic [19:0] in_bus;
  logic [1:0]  sel;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  out_data;
  logic [1:0]  out_sel;
  logic        out_err;
  logic        out_valid;
  logic        out_ready;

  logic [14:0] in_bus3;
  logic [1:0]  sel3;
  logic        in_valid3;
  logic        in_ready3;
  logic [4:0]  out_data3;
  logic [1:0]  out_sel3;
  logic        out_err3;
  logic        out_valid3;
  logic        out_ready3;

  int checks;
  int errors;

  mux_pipe_sel #(.WIDTH(5), .NUM_IN(4)) u_dut (
    .clk(clk), .rst(rst), .in_bus(in_bus), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_sel(out_sel), .out_err(out_err),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  mux_pipe_sel #(.WIDTH(5), .NUM_IN(3)) u_dut3 (
    .clk(clk), .rst(rst), .in_bus(in_bus3), .sel(sel3),
    .in_valid(in_valid3), .in_ready(in_ready3),
    .out_data(out_data3), .out_sel(out_sel3), .out_err(out_err3),
    .out_valid(out_valid3), .out_ready(out_ready3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [4:0] exp_tab [4];
  logic [7:0] sb [$];
  logic [7:0] head;
  logic [4:0] exp_d;
  bit         ifire;
  bit         ofire;

  initial begin
    checks     = 0;
    errors     = 0;
    exp_tab[0] = 5'h01;
    exp_tab[1] = 5'h0A;
    exp_tab[2] = 5'h15;
    exp_tab[3] = 5'h1F;

    rst        = 1'b1;
    in_bus     = {5'h1F, 5'h15, 5'h0A, 5'h01};
    sel        = 2'd0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    in_bus3    = {5'h15, 5'h0A, 5'h01};
    sel3       = 2'd0;
    in_valid3  = 1'b0;
    out_ready3 = 1'b1;

    // Reset state
    step();
    step();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data",  32'(out_data),  32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd0);
    rst = 1'b0;
    step();
    check("rel_in_ready", 32'(in_ready), 32'd1);

    // Back-to-back stream, 1-cycle latency
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel = 2'(i);
      step();
      check("b2b_valid", 32'(out_valid), 32'd1);
      check("b2b_data",  32'(out_data),  32'(exp_tab[i]));
      check("b2b_sel",   32'(out_sel),   32'(i));
      check("b2b_err",   32'(out_err),   32'd0);
    end
    in_valid = 1'b0;
    step();
    check("b2b_drain", 32'(out_valid), 32'd0);

    // Stall into the skid buffer, then drain
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel       = 2'd1;
    step();
    check("stall_d0",  32'(out_data), 32'h0A);
    check("stall_rdy0", 32'(in_ready), 32'd1);
    sel = 2'd2;
    step();
    check("stall_d1",  32'(out_data), 32'h0A);
    check("stall_full", 32'(in_ready), 32'd0);
    sel = 2'd3;           // offered while full: must be ignored
    step();
    check("stall_hold", 32'(out_data), 32'h0A);
    check("stall_sel",  32'(out_sel),  32'd1);
    check("stall_full2", 32'(in_ready), 32'd0);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    check("drain_d",   32'(out_data),  32'h15);
    check("drain_v",   32'(out_valid), 32'd1);
    check("drain_rdy", 32'(in_ready),  32'd1);
    step();
    check("drain_empty", 32'(out_valid), 32'd0);

    // Continuous in_fire & out_fire
    in_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      sel = 2'(i % 4);
      step();
      check("stream_d",   32'(out_data), 32'(exp_tab[i % 4]));
      check("stream_rdy", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    step();
    check("stream_end", 32'(out_valid), 32'd0);

    // Out-of-range select on the 3-input instance
    in_valid3 = 1'b1;
    sel3      = 2'd3;
    step();
    check("oor_valid", 32'(out_valid3), 32'd1);
    check("oor_data",  32'(out_data3),  32'd0);
    check("oor_err",   32'(out_err3),   32'd1);
    check("oor_sel",   32'(out_sel3),   32'd3);
    sel3 = 2'd0;
    step();
    check("oor_next_d",   32'(out_data3), 32'h01);
    check("oor_next_err", 32'(out_err3),  32'd0);
    sel3 = 2'd2;
    step();
    check("oor_last_d", 32'(out_data3), 32'h15);
    in_valid3 = 1'b0;
    step();

    // Reset while full: both beats dropped asynchronously
    out_ready = 1'b0;
    in_valid  = 1'b1;
    sel       = 2'd3;
    step();
    sel = 2'd0;
    step();
    check("mid_full", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    check("mid_valid", 32'(out_valid), 32'd0);
    check("mid_data",  32'(out_data),  32'd0);
    check("mid_rdy",   32'(in_ready),  32'd0);
    #1;
    rst = 1'b0;
    step();
    check("mid_rel_rdy",   32'(in_ready),  32'd1);
    check("mid_rel_valid", 32'(out_valid), 32'd0);

    // Random handshakes against a FIFO scoreboard of {data, sel}
    sb.delete();
    for (int c = 0; c < 3000; c++) begin
      in_valid  = 1'($urandom_range(1));
      out_ready = 1'($urandom_range(1));
      sel       = 2'($urandom_range(3));
      in_bus    = 20'($urandom);
      #1;
      check("rnd_valid", 32'(out_valid), 32'(sb.size() > 0));
      check("rnd_rdy",   32'(in_ready),  32'(sb.size() < 2));
      if (sb.size() > 0) begin
        head = sb[0];
        check("rnd_data", 32'(out_data), 32'(head[6:2]));
        check("rnd_sel",  32'(out_sel),  32'(head[1:0]));
        check("rnd_err",  32'(out_err),  32'd0);
      end
      ifire = in_valid && (sb.size() < 2);
      ofire = out_ready && (sb.size() > 0);
      exp_d = in_bus[sel*5 +: 5];
      step();
      if (ofire) void'(sb.pop_front());
      if (ifire) sb.push_back({1'b0, exp_d, sel});
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
